// File: rtl/sys_pkg.sv
// Shared definitions for the systolic operand feeders: feeder state encoding,
// default array geometry and a lane-slice helper for N*DW packed words.
package sys_pkg;

    localparam int SYS_N  = 4;
    localparam int SYS_DW = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } feed_state_e;

    function automatic logic [SYS_DW-1:0] lane_slice(
        input logic [SYS_N*SYS_DW-1:0] word,
        input int                      lane
    );
        return word[lane*SYS_DW +: SYS_DW];
    endfunction

endpackage

// File: rtl/sys_skew_line.sv
// Stall-able delay line of DEPTH stages carrying data plus a valid bit.
// DEPTH 0 passes the input straight through.
module sys_skew_line
    import sys_pkg::*;
#(
    parameter int DEPTH = 1,
    parameter int DW    = SYS_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          adv,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          inner_valid
);

    generate
        if (DEPTH == 0) begin : g_thru
            logic unused_ok;
            assign unused_ok   = ^{clk, rst_n, adv};
            assign out_valid   = in_valid;
            assign out_data    = in_data;
            assign inner_valid = 1'b0;
        end else begin : g_pipe
            logic [DEPTH-1:0] valid_q, valid_d;
            logic [DW-1:0]    data_q [DEPTH];
            logic [DW-1:0]    data_d [DEPTH];

            // Data only moves with a valid element so the lane output holds its last value.
            always_comb begin
                valid_d = valid_q;
                data_d  = data_q;
                if (adv) begin
                    valid_d[0] = in_valid;
                    if (in_valid) begin
                        data_d[0] = in_data;
                    end
                    for (int i = 1; i < DEPTH; i++) begin
                        valid_d[i] = valid_q[i-1];
                        if (valid_q[i-1]) begin
                            data_d[i] = data_q[i-1];
                        end
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_q <= '0;
                    for (int i = 0; i < DEPTH; i++) begin
                        data_q[i] <= '0;
                    end
                end else begin
                    valid_q <= valid_d;
                    data_q  <= data_d;
                end
            end

            assign out_valid = valid_q[DEPTH-1];
            assign out_data  = data_q[DEPTH-1];

            if (DEPTH > 1) begin : g_inner
                assign inner_valid = |valid_q[DEPTH-2:0];
            end else begin : g_noinner
                assign inner_valid = 1'b0;
            end
        end
    endgenerate

endmodule

// File: rtl/sys_skew_feeder.sv
// Operand feeder: reads one matrix operand from buffer RAM and streams it, skewed by lane,
// into the edge PEs with full-flag backpressure. SYS_FEEDER_PERF_EN adds a stall_cnt output.
module sys_skew_feeder
    import sys_pkg::*;
#(
    parameter int N  = SYS_N,
    parameter int DW = SYS_DW,
    parameter int AW = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [AW-1:0]   base_adr,
    input  logic [7:0]      max_cntr,
    output logic            rd_en,
    output logic [AW-1:0]   rd_adr,
    input  logic [N*DW-1:0] rd_data,
    input  logic [N-1:0]    ff,
    output logic [N*DW-1:0] d_out,
    output logic [N-1:0]    we_out,
    output logic            busy,
    output logic            done
`ifdef SYS_FEEDER_PERF_EN
    ,
    output logic [15:0]     stall_cnt
`endif
);

    feed_state_e     state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [7:0]      max_q, max_d;
    logic [AW-1:0]   adr_q, adr_d;
    logic            rd_pend_q, rd_pend_d;
    logic            hold_valid_q, hold_valid_d;
    logic [N*DW-1:0] hold_data_q, hold_data_d;
    logic            s0_valid_q, s0_valid_d;
    logic [N*DW-1:0] s0_data_q, s0_data_d;

    logic            stall;
    logic            adv;
    logic            drain_clear;
    logic [N-1:0]    lane_valid;
    logic [N-1:0]    lane_inner;

    assign stall = |ff;
    assign adv   = ~stall;

    // Safe to leave DRAIN once the only valid elements left sit in the lane output stages and
    // are being emitted this cycle; stage 0 is an output stage only when there is a single lane.
    assign drain_clear = adv && !rd_pend_q && !hold_valid_q &&
                         !((N > 1) && s0_valid_q) && !(|lane_inner);

    assign rd_adr = adr_q;
    assign busy   = (state_q != ST_IDLE);
    assign done   = (state_q == ST_DONE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        max_d   = max_q;
        adr_d   = adr_q;
        rd_en   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FETCH;
                    cnt_d   = '0;
                    max_d   = max_cntr;
                    adr_d   = base_adr;
                end
            end
            ST_FETCH: begin
                if (adv) begin
                    rd_en = 1'b1;
                    adr_d = adr_q + 1'b1;
                    if (cnt_q == max_q) begin
                        state_d = ST_DRAIN;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_clear) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // A word returning into a stalled cycle is parked in the hold register; reads stop while
    // stalled, so the hold slot and a fresh return can never collide.
    always_comb begin
        rd_pend_d    = rd_en;
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        s0_valid_d   = s0_valid_q;
        s0_data_d    = s0_data_q;
        if (stall) begin
            if (rd_pend_q) begin
                hold_valid_d = 1'b1;
                hold_data_d  = rd_data;
            end
        end else begin
            hold_valid_d = 1'b0;
            s0_valid_d   = hold_valid_q | rd_pend_q;
            if (hold_valid_q) begin
                s0_data_d = hold_data_q;
            end else if (rd_pend_q) begin
                s0_data_d = rd_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            max_q        <= '0;
            adr_q        <= '0;
            rd_pend_q    <= 1'b0;
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
            s0_valid_q   <= 1'b0;
            s0_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            max_q        <= max_d;
            adr_q        <= adr_d;
            rd_pend_q    <= rd_pend_d;
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
            s0_valid_q   <= s0_valid_d;
            s0_data_q    <= s0_data_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_lane
            logic [DW-1:0] lane_data;

            sys_skew_line #(
                .DEPTH (gi),
                .DW    (DW)
            ) u_line (
                .clk         (clk),
                .rst_n       (rst_n),
                .adv         (adv),
                .in_valid    (s0_valid_q),
                .in_data     (s0_data_q[gi*DW +: DW]),
                .out_valid   (lane_valid[gi]),
                .out_data    (lane_data),
                .inner_valid (lane_inner[gi])
            );

            assign d_out[gi*DW +: DW] = lane_data;
            assign we_out[gi]         = lane_valid[gi] & adv;
        end
    endgenerate

`ifdef SYS_FEEDER_PERF_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((state_q == ST_IDLE) && start) begin
            stall_cnt_d = '0;
        end else if (busy && stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_sys_skew_feeder.sv
// Scoreboard bench for sys_skew_feeder: stimulus pushes expected addresses and per-lane elements,
// a negedge monitor pops and compares whenever the DUT strobes rd_en, we_out or done.
module tb_sys_skew_feeder;
    import sys_pkg::*;

    localparam int N  = SYS_N;
    localparam int DW = SYS_DW;
    localparam int AW = 10;
    localparam int W  = N * DW;

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_adr = '0;
    logic [7:0]    max_cntr = '0;
    logic          rd_en;
    logic [AW-1:0] rd_adr;
    logic [W-1:0]  rd_data;
    logic [N-1:0]  ff = '0;
    logic [W-1:0]  d_out;
    logic [N-1:0]  we_out;
    logic          busy;
    logic          done;
`ifdef SYS_FEEDER_PERF_EN
    logic [15:0]   stall_cnt;
`endif

    sys_skew_feeder #(.N(N), .DW(DW), .AW(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_adr  (base_adr),
        .max_cntr  (max_cntr),
        .rd_en     (rd_en),
        .rd_adr    (rd_adr),
        .rd_data   (rd_data),
        .ff        (ff),
        .d_out     (d_out),
        .we_out    (we_out),
        .busy      (busy),
        .done      (done)
`ifdef SYS_FEEDER_PERF_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    logic [W-1:0] ram [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (rd_en) rd_data <= ram[rd_adr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   checks = 0;
    int   errors = 0;
    exp_t lane_q [N][$];
    int   adr_exp [$];
    bit   feed_active = 1'b0;
    bit   done_seen = 1'b0;
    int   start_cyc = 0;
    int   m_exp = 0;
    int   stalls = 0;
    int   stalls_busy = 0;
    int   done_cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic note_fail(input string name, input logic [63:0] act);
        checks++;
        errors++;
        $display("FAIL %s actual=%0h required=no event (cycle %0d)", name, act, cyc);
    endtask

    task automatic flush();
        for (int i = 0; i < N; i++) lane_q[i].delete();
        adr_exp.delete();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_rd_en"},  64'(rd_en),  64'd0);
        chk({tag, "_rd_adr"}, 64'(rd_adr), 64'd0);
        chk({tag, "_we_out"}, 64'(we_out), 64'd0);
        chk({tag, "_d_out"},  64'(d_out),  64'd0);
        chk({tag, "_busy"},   64'(busy),   64'd0);
        chk({tag, "_done"},   64'(done),   64'd0);
`ifdef SYS_FEEDER_PERF_EN
        chk({tag, "_stall_cnt"}, 64'(stall_cnt), 64'd0);
`endif
    endtask

    // Monitor: every DUT strobe is matched against the scoreboard.
    always @(negedge clk) begin
        bit   pre_done;
        exp_t e;
        int   a;
        if (rst_n) begin
            pre_done = done_seen;
            if (done) begin
                if (!feed_active || done_seen) begin
                    note_fail("done_unexpected", 64'(done));
                end else begin
                    chk("done_cycle", 64'(cyc), 64'(start_cyc + N + 3 + m_exp + stalls));
                    done_seen = 1'b1;
                    done_cyc  = cyc;
                end
            end
            if (ff != '0) begin
                chk("stall_we_out", 64'(we_out), 64'd0);
                chk("stall_rd_en",  64'(rd_en),  64'd0);
            end
            if (rd_en) begin
                if (adr_exp.size() == 0) begin
                    note_fail("rd_unexpected", 64'(rd_adr));
                end else begin
                    a = adr_exp.pop_front();
                    chk("rd_adr", 64'(rd_adr), 64'(a));
                end
            end
            for (int i = 0; i < N; i++) begin
                if (we_out[i]) begin
                    if (lane_q[i].size() == 0) begin
                        note_fail($sformatf("lane%0d_extra", i), 64'(lane_slice(d_out, i)));
                    end else begin
                        e = lane_q[i].pop_front();
                        chk($sformatf("lane%0d_data", i), 64'(lane_slice(d_out, i)), 64'(e.data));
                        if (e.cyc >= 0) chk($sformatf("lane%0d_cycle", i), 64'(cyc), 64'(e.cyc));
                    end
                end
            end
            if (feed_active && (cyc > start_cyc) && !pre_done && (ff != '0)) begin
                stalls_busy++;
                if (!done) stalls++;
            end
        end
    end

    // One feed: model = RAM[base+k mod 2^AW] sliced per lane; every stalled busy cycle shifts
    // everything by one; nominal lane i element k at start+3+i+k, done at start+N+3+max_cntr.
    task automatic run_feed(input logic [AW-1:0] base, input int m, input bit timed,
                            input int st_at, input int st_len, input logic [N-1:0] st_val,
                            input int pct, input bit repulse, input int rst_at);
        logic [AW-1:0] a;
        exp_t          e;
        bit            was_reset;
        int            left;
        was_reset   = 1'b0;
        start_cyc   = cyc;
        m_exp       = m;
        stalls      = 0;
        stalls_busy = 0;
        done_seen   = 1'b0;
        for (int k = 0; k <= m; k++) begin
            a = base + AW'(k);
            adr_exp.push_back(int'(a));
            for (int i = 0; i < N; i++) begin
                e.data = lane_slice(ram[a], i);
                e.cyc  = timed ? start_cyc + 3 + i + k : -1;
                lane_q[i].push_back(e);
            end
        end
        feed_active = 1'b1;
        for (int t = 0; t < 400 && !done_seen; t++) begin
            start    = (t == 0) || (repulse && t == 2);
            base_adr = (t == 0) ? base : AW'($urandom);
            max_cntr = (t == 0) ? 8'(m) : 8'($urandom);
            if (t >= st_at && t < st_at + st_len) ff = st_val;
            else if (pct > 0 && $urandom_range(99) < pct) ff = N'($urandom_range(1, (1 << N) - 1));
            else ff = '0;
            if (t == rst_at) begin
                start = 1'b0;
                ff    = '0;
                #2 rst_n = 1'b0;
                #1 check_zero("reset_mid");
                flush();
                feed_active = 1'b0;
                repeat (2) @(posedge clk);
                #1 rst_n = 1'b1;
                was_reset = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        ff    = '0;
        if (!was_reset) begin
            if (!done_seen) note_fail("done_timeout", 64'(cyc));
            chk("busy_after_done", 64'(busy), 64'd0);
            left = 0;
            for (int i = 0; i < N; i++) left += lane_q[i].size();
            chk("lane_leftover", 64'(left), 64'd0);
            chk("adr_leftover", 64'(adr_exp.size()), 64'd0);
`ifdef SYS_FEEDER_PERF_EN
            chk("stall_cnt", 64'(stall_cnt), 64'(stalls_busy));
`endif
            $display("feed base=%03h max=%0d start=%0d done=%0d stalls=%0d",
                     base, m, start_cyc, done_cyc, stalls);
            flush();
            feed_active = 1'b0;
        end else begin
            $display("feed base=%03h max=%0d start=%0d reset mid-feed", base, m, start_cyc);
        end
    endtask

    initial begin
        logic [DW-1:0] v;
        for (int i = 0; i < (1 << AW); i++) begin
            for (int j = 0; j < N; j++) ram[i][j*DW +: DW] = DW'($urandom);
        end
        for (int k = 0; k < 4; k++) begin
            v = DW'(k + 1);
            ram[10'h010 + k] = {N{v}};
        end

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        run_feed(10'h010, 3, 1'b1, -1, 0, '0,        0, 1'b0, -1);
        run_feed(10'h040, 5, 1'b0,  3, 3, 4'b0100,   0, 1'b0, -1);
        run_feed(10'h080, 5, 1'b0,  2, 1, 4'b0001,   0, 1'b0, -1);
        run_feed(10'h0C0, 0, 1'b1, -1, 0, '0,        0, 1'b1, -1);
        run_feed(10'h3FE, 3, 1'b1, -1, 0, '0,        0, 1'b0, -1);
        run_feed(10'h100, 3, 1'b0, -1, 0, '0,        0, 1'b0,  7);
        run_feed(10'h120, 2, 1'b1, -1, 0, '0,        0, 1'b0, -1);
        for (int r = 0; r < 20; r++) begin
            run_feed(AW'($urandom), int'($urandom_range(0, 7)), 1'b0, -1, 0, '0, 25, 1'b0, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
